// File: rtl/uart_fifo_param.sv
// rtl/uart_fifo_param.sv - parametrised buffered UART with TX/RX FIFOs
//
// A TX FIFO feeds a serialiser and a deserialiser feeds an RX FIFO.
// Optional parity is enabled by defining UART_PARITY_EN.
// Without that macro, no parity bit is framed and parity_err stays 0.
//
// Ports:
//   clk, rst            single rising-edge clock, async active-high reset
//   tx_data, tx_en      push a word into the TX FIFO
//   tx_full, tx_count   TX FIFO status (registered)
//   rx_next             pop the RX FIFO head
//   rx_data, rx_empty   RX FIFO head (first-word fall-through) and status
//   rx_count            RX FIFO occupancy
//   rx_overrun          sticky: received word dropped on a full RX FIFO
//   frame_err           sticky: first stop bit sampled low
//   parity_err          sticky: parity mismatch (0 without UART_PARITY_EN)
//   err_clr             clear all sticky flags (a same-cycle set wins)
//   rx, tx              serial line in (asynchronous) / out (registered)
module uart_fifo_param #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_en,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  input  logic                          rx_next,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  input  logic                          err_clr,
  input  logic                          rx,
  output logic                          tx
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    DEPTH     = CW'(FIFO_DEPTH);
  localparam logic             ODD       = 1'(PARITY_ODD);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;   // RX only: wait for line high after a framing error

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic              tx_full_q, tx_full_d;
  logic              tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_head = tx_mem_q[tx_rd_q];

  always_comb begin
    tx_push   = tx_en && (!tx_full_q || tx_pop);
    tx_wr_d   = tx_wr_q + AW'(tx_push);
    tx_rd_d   = tx_rd_q + AW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    tx_full_d = (tx_cnt_d == DEPTH);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
  end

  // ---------------- TX FSM ----------------
  logic [2:0]        tx_st_q, tx_st_d;
  logic [CNT_W-1:0]  tx_tick_q, tx_tick_d;
  logic [3:0]        tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_q, tx_d;
  logic              tx_load;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_tick_d = tx_tick_q;
    tx_idx_d  = tx_idx_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_d      = tx_q;
    tx_load   = 1'b0;
    if (tx_st_q == S_IDLE) begin
      tx_load = (tx_cnt_q != '0);
    end else if (tx_tick_q != BIT_LAST) begin
      tx_tick_d = tx_tick_q + 1'b1;
    end else begin
      tx_tick_d = '0;
      case (tx_st_q)
        S_START: begin
          tx_st_d  = S_DATA;
          tx_idx_d = '0;
          tx_d     = tx_sh_q[0];
        end
        S_DATA: begin
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_d = '0;
            tx_st_d  = HAS_PAR ? S_PAR : S_STOP;
            tx_d     = HAS_PAR ? tx_par_q : 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end
        S_PAR: begin
          tx_st_d = S_STOP;
          tx_d    = 1'b1;
        end
        S_STOP: begin
          if (tx_idx_q == STOP_LAST) begin
            // Chain straight into the next start bit when more data waits.
            tx_load = (tx_cnt_q != '0);
            tx_st_d = S_IDLE;
            tx_d    = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
        default: begin
          tx_st_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    if (tx_load) begin
      tx_st_d   = S_START;
      tx_tick_d = '0;
      tx_idx_d  = '0;
      tx_sh_d   = tx_head;
      tx_par_d  = (^tx_head) ^ ODD;
      tx_d      = 1'b0;
    end
    tx_pop = tx_load;
  end

  // ---------------- RX FSM ----------------
  logic              rx_s1_q, rx_s2_q;
  logic [2:0]        rx_st_q, rx_st_d;
  logic [CNT_W-1:0]  rx_tick_q, rx_tick_d;
  logic [3:0]        rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_pbit_q, rx_pbit_d;
  logic              rx_push, frame_set, par_set;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_tick_d = rx_tick_q;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    rx_pbit_d = rx_pbit_q;
    rx_push   = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    case (rx_st_q)
      // IDLE is only entered with the line high, so a low level here is a falling edge.
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_st_d   = S_START;
          rx_tick_d = '0;
        end
      end
      S_START: begin
        if (rx_tick_q == HALF_LAST) begin
          rx_tick_d = '0;
          rx_idx_d  = '0;
          rx_st_d   = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_tick_d = rx_tick_q + 1'b1;
        end
      end
      S_DATA, S_PAR, S_STOP: begin
        if (rx_tick_q != BIT_LAST) begin
          rx_tick_d = rx_tick_q + 1'b1;
        end else begin
          rx_tick_d = '0;
          if (rx_st_q == S_DATA) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
            if (rx_idx_q == DATA_LAST) rx_st_d = HAS_PAR ? S_PAR : S_STOP;
            else                       rx_idx_d = rx_idx_q + 1'b1;
          end else if (rx_st_q == S_PAR) begin
            rx_pbit_d = rx_s2_q;
            rx_st_d   = S_STOP;
          end else if (!rx_s2_q) begin
            frame_set = 1'b1;
            rx_st_d   = S_BREAK;
          end else begin
            rx_st_d = S_IDLE;
            if (HAS_PAR && (((^rx_sh_q) ^ rx_pbit_q) != ODD)) par_set = 1'b1;
            else                                                rx_push = 1'b1;
          end
        end
      end
      S_BREAK: if (rx_s2_q) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO + flags ----------------
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic              rx_empty_q, rx_empty_d;
  logic              rx_pop, rx_accept, ovr_set;
  logic              rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;

  always_comb begin
    rx_pop       = rx_next && !rx_empty_q;
    rx_accept    = rx_push && ((rx_cnt_q != DEPTH) || rx_pop);
    ovr_set      = rx_push && !rx_accept;
    rx_wr_d      = rx_wr_q + AW'(rx_accept);
    rx_rd_d      = rx_rd_q + AW'(rx_pop);
    rx_cnt_d     = rx_cnt_q + CW'(rx_accept) - CW'(rx_pop);
    rx_empty_d   = (rx_cnt_d == '0);
    rx_overrun_d = ovr_set   | (rx_overrun_q & ~err_clr);
    frame_err_d  = frame_set | (frame_err_q  & ~err_clr);
    parity_err_d = par_set   | (parity_err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem_q[rx_wr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q <= '0; tx_rd_q <= '0; tx_cnt_q <= '0; tx_full_q <= 1'b0;
      tx_st_q <= S_IDLE; tx_tick_q <= '0; tx_idx_q <= '0;
      tx_sh_q <= '0; tx_par_q <= 1'b0; tx_q <= 1'b1;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1;
      rx_st_q <= S_IDLE; rx_tick_q <= '0; rx_idx_q <= '0;
      rx_sh_q <= '0; rx_pbit_q <= 1'b0;
      rx_wr_q <= '0; rx_rd_q <= '0; rx_cnt_q <= '0; rx_empty_q <= 1'b1;
      rx_overrun_q <= 1'b0; frame_err_q <= 1'b0; parity_err_q <= 1'b0;
    end else begin
      tx_wr_q <= tx_wr_d; tx_rd_q <= tx_rd_d; tx_cnt_q <= tx_cnt_d; tx_full_q <= tx_full_d;
      tx_st_q <= tx_st_d; tx_tick_q <= tx_tick_d; tx_idx_q <= tx_idx_d;
      tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d; tx_q <= tx_d;
      rx_s1_q <= rx; rx_s2_q <= rx_s1_q;
      rx_st_q <= rx_st_d; rx_tick_q <= rx_tick_d; rx_idx_q <= rx_idx_d;
      rx_sh_q <= rx_sh_d; rx_pbit_q <= rx_pbit_d;
      rx_wr_q <= rx_wr_d; rx_rd_q <= rx_rd_d; rx_cnt_q <= rx_cnt_d; rx_empty_q <= rx_empty_d;
      rx_overrun_q <= rx_overrun_d; frame_err_q <= frame_err_d; parity_err_q <= parity_err_d;
    end
  end

  assign tx         = tx_q;
  assign tx_full    = tx_full_q;
  assign tx_count   = tx_cnt_q;
  assign rx_empty   = rx_empty_q;
  assign rx_count   = rx_cnt_q;
  assign rx_data    = rx_empty_q ? '0 : rx_mem_q[rx_rd_q];
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
endmodule

// File: tb/tb_uart_fifo_param.sv
// tb/tb_uart_fifo_param.sv - directed self-checking bench for uart_fifo_param
module tb_uart_fifo_param;
  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int CPB = 8;
  localparam int STB = 1;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_en = 1'b0;
  logic          tx_full;
  logic [4:0]    tx_count;
  logic          rx_next = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_empty;
  logic [4:0]    rx_count;
  logic          rx_overrun, frame_err, parity_err;
  logic          err_clr = 1'b0;
  logic          tx;
  logic          loop_en = 1'b0;
  logic          rx_drv = 1'b1;
  logic          rx_w;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] mon_q [$];

  assign rx_w = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_param #(
    .DATA_W(DW), .FIFO_DEPTH(DEP), .CLKS_PER_BIT(CPB), .STOP_BITS(STB), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_en(tx_en), .tx_full(tx_full),
    .tx_count(tx_count), .rx_next(rx_next), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_count(rx_count), .rx_overrun(rx_overrun), .frame_err(frame_err),
    .parity_err(parity_err), .err_clr(err_clr), .rx(rx_w), .tx(tx)
  );

  // Independent serial decoder on tx: mid-bit sampling, parity bit skipped.
  always begin : tx_monitor
    logic [DW-1:0] w;
    @(negedge clk);
    if (tx === 1'b0 && !rst) begin
      repeat (CPB / 2) @(negedge clk);
      if (tx === 1'b0) begin
        for (int i = 0; i < DW; i++) begin
          repeat (CPB) @(negedge clk);
          w[i] = tx;
        end
        repeat ((P + 1) * CPB) @(negedge clk);
        mon_q.push_back(w);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    tx_data = d;
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] exp);
    check(tag, rx_data, exp);
    rx_next = 1'b1;
    @(negedge clk);
    rx_next = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop_v);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_drv = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (P == 1) begin
      rx_drv = par;
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_v;
    repeat (CPB * STB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_flags", {rx_overrun, frame_err, parity_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback A..D, with push-to-start-bit latency on the first word
    loop_en = 1'b1;
    push(8'h41);
    check("lat_count_up", tx_count, 1);
    check("lat_tx_idle", tx, 1);
    @(negedge clk);
    check("lat_start_bit", tx, 0);
    check("lat_count_pop", tx_count, 0);
    push(8'h42); push(8'h43); push(8'h44);
    for (int i = 0; i < 1500 && rx_count != 5'd4; i++) @(negedge clk);
    check("lb_rx_count", rx_count, 4);
    check("lb_rx_empty", rx_empty, 0);
    for (int i = 0; i < 4; i++) pop_check("lb_data", 8'(8'h41 + i));
    check("lb_empty_after", rx_empty, 1);
    check("lb_flags", {rx_overrun, frame_err, parity_err}, 0);

    // TX overflow without loopback: busy FSM, then 17 pushes -> one dropped
    loop_en = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    mon_q.delete();
    push(8'h0F);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    check("txf_full", tx_full, 1);
    check("txf_count", tx_count, 16);
    for (int i = 0; i < 3000 && tx_count != 5'd0; i++) @(negedge clk);
    repeat (12 * CPB) @(negedge clk);
    check("txf_count_zero", tx_count, 0);
    check("txf_full_clear", tx_full, 0);
    check("txf_n_words", mon_q.size(), 17);
    if (mon_q.size() == 17) begin
      check("txf_word0", mon_q[0], 8'h0F);
      for (int i = 1; i < 17; i++) check("txf_word", mon_q[i], 8'(8'h0F + i));
    end

    // RX overrun in loopback, never popping
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 3000 && tx_count != 5'd0; i++) @(negedge clk);
    repeat (15 * CPB) @(negedge clk);
    check("ovr_rx_count", rx_count, 16);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_no_frame_err", frame_err, 0);
    clear_errs();
    check("ovr_cleared", rx_overrun, 0);
    for (int i = 0; i < 16; i++) pop_check("ovr_data", 8'(8'h30 + i));
    check("ovr_empty_after", rx_empty, 1);

    // Framing error then a good frame
    loop_en = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b0);
    check("fe_flag", frame_err, 1);
    check("fe_discard", rx_empty, 1);
    send_frame(8'hA3, ^8'hA3, 1'b1);
    check("fe_good_empty", rx_empty, 0);
    check("fe_good_count", rx_count, 1);
    pop_check("fe_good_data", 8'hA3);
    check("fe_sticky", frame_err, 1);
    clear_errs();
    check("fe_cleared", frame_err, 0);

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_flag", parity_err, 1);
    check("par_discard", rx_empty, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_good_empty", rx_empty, 0);
    pop_check("par_good_data", 8'h07);
    clear_errs();
    check("par_cleared", parity_err, 0);
`endif

    // Reset mid-frame during the TX data phase, with one word in the RX FIFO
    send_frame(8'h5A, ^8'h5A, 1'b1);
    check("mr_rx_count_pre", rx_count, 1);
    push(8'h00); push(8'h01); push(8'h02);
    repeat (2 * CPB) @(negedge clk);
    check("mr_tx_low_pre", tx, 0);
    rst = 1'b1;
    #1;
    check("mr_tx_high", tx, 1);
    check("mr_tx_count", tx_count, 0);
    check("mr_tx_full", tx_full, 0);
    check("mr_rx_count", rx_count, 0);
    check("mr_rx_empty", rx_empty, 1);
    check("mr_rx_data", rx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Short low glitch on rx must be rejected silently
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("gl_rx_empty", rx_empty, 1);
    check("gl_rx_count", rx_count, 0);
    check("gl_flags", {rx_overrun, frame_err, parity_err}, 0);
    check("gl_tx_idle", tx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
